reg_file_param: RTL and testbench
=================================

Name: reg_file_param

Overview:
- Parametrised multi-port register file; successor to the fixed 32-bit flop register.
- Generalised in data width and register count, with write enable, two read ports and an optional hard-wired zero register.
- Sits in the MIPS datapath decode stage: rs/rt reads, writeback from the WB stage.

Parameters:
- WIDTH, 32, data bits per register.
- ADDR_W, 5, address bits; depth = 2**ADDR_W registers.
- ZERO_REG, 1, when 1 register 0 reads as 0 and ignores writes; when 0 it is an ordinary register.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low; 0 clears every register immediately, regardless of clk.
- we  input  1  write enable, sampled on the rising clk edge.
- waddr  input  ADDR_W  write address.
- wdata  input  WIDTH  write data.
- raddr1  input  ADDR_W  read address, port 1.
- rdata1  output  WIDTH  read data, port 1.
- raddr2  input  ADDR_W  read address, port 2.
- rdata2  output  WIDTH  read data, port 2.

Behaviour:
- Storage: 2**ADDR_W registers of WIDTH bits each.
- Reset:
  - reset=0 asynchronously forces every register to 0.
  - rdata1 and rdata2 therefore read 0 during reset and after release until written.
  - Writes are ignored while reset=0.
  - Reset asserted mid-write wins: that edge's write is lost.
- Write:
  - On rising clk with reset=1 and we=1, reg[waddr] <= wdata.
  - Write latency is 1 cycle: the new value is visible on reads from the edge onward.
  - we=0 leaves all registers unchanged; waddr and wdata are don't-care.
- Read:
  - Combinational, zero latency: rdataN = reg[raddrN].
  - Both ports are independent and may address the same register.
- Zero register (ZERO_REG=1):
  - A write to waddr=0 is discarded.
  - raddrN=0 always returns 0, including under the bypass feature.
- Same-cycle read/write collision (we=1, raddrN==waddr), without the optional feature:
  - rdataN returns the old stored value before the edge and the new value after it.
- Address width: full decode, no out-of-range addresses. Depth is always a power of two.
- No X propagation: all registers are defined from reset onward.

Optional Feature:
- Macro: REG_FILE_BYPASS_EN.
- Defined: write-to-read forwarding.
  - When we=1, reset=1 and raddrN==waddr (and waddr!=0 if ZERO_REG=1), rdataN = wdata combinationally in the same cycle, before the edge.
  - Removes a WB-to-ID hazard stall.
- Not defined: no forwarding; collision behaviour as in Behaviour.
- The stored-state update is identical in both builds; only the read mux differs.

Test Plan:
- Reset: hold reset=0, toggle clk 3 cycles, read raddr1=7, raddr2=31 -> rdata1=rdata2=32'h0. Release reset; still 0.
- Write/read: we=1, waddr=5, wdata=32'hAFAFAFAF, one edge; then we=0, raddr1=5 -> rdata1=32'hAFAFAFAF. raddr2=6 -> 32'h0.
- Zero register: ZERO_REG=1, we=1, waddr=0, wdata=32'hDEADBEEF, one edge -> raddr1=0 gives 32'h0. Rebuild with ZERO_REG=0 -> 32'hDEADBEEF.
- Collision: reg[9]=32'h11111111; we=1, waddr=9, wdata=32'h22222222, raddr1=9 before the edge -> rdata1=32'h11111111 without REG_FILE_BYPASS_EN, 32'h22222222 with it. After the edge, 32'h22222222 in both builds.
- Async reset mid-operation: registers 1..31 loaded with their index; assert reset=0 between clk edges -> both ports read 0 at once. An edge with we=1, waddr=3 during reset leaves reg[3]=0.
- Parameter sweep: WIDTH=8, ADDR_W=3; write 8'hFF to address 7 and 8'h01 to address 1 -> reads return 8'hFF and 8'h01; all other addresses read 0.

Source files
------------

// File: rtl/reg_file_param_if.sv
// Register-file access bundle: one write port and two combinational read ports.
// The master drives addresses, write data and write enable; the slave returns read data.
interface reg_file_param_if #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5
);
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [WIDTH-1:0]  wdata;
  logic [ADDR_W-1:0] raddr1;
  logic [WIDTH-1:0]  rdata1;
  logic [ADDR_W-1:0] raddr2;
  logic [WIDTH-1:0]  rdata2;

  modport master (
    output we, waddr, wdata, raddr1, raddr2,
    input  rdata1, rdata2
  );

  modport slave (
    input  we, waddr, wdata, raddr1, raddr2,
    output rdata1, rdata2
  );
endinterface

// File: rtl/reg_file_param.sv
// Parametrised 2-read/1-write register file with optional hard-wired zero register.
// Define REG_FILE_BYPASS_EN to forward same-cycle write data onto a matching read port.
module reg_file_param #(
  parameter int WIDTH    = 32,
  parameter int ADDR_W   = 5,
  parameter bit ZERO_REG = 1'b1
) (
  input logic              clk,
  input logic              reset,
  reg_file_param_if.slave  bus
);
  localparam int DEPTH = 2 ** ADDR_W;

  logic [WIDTH-1:0] regs [DEPTH];
  logic             wr_ok;
  logic             fwd_ok;
  logic [WIDTH-1:0] rd1;
  logic [WIDTH-1:0] rd2;

  // Writes to the zero register are dropped here, so its flop never leaves reset.
  assign wr_ok  = bus.we && !(ZERO_REG && (bus.waddr == '0));
  assign fwd_ok = wr_ok && reset;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_ok) begin
      regs[bus.waddr] <= bus.wdata;
    end
  end

  always_comb begin
    rd1 = regs[bus.raddr1];
    if (ZERO_REG && (bus.raddr1 == '0)) begin
      rd1 = '0;
    end
`ifdef REG_FILE_BYPASS_EN
    else if (fwd_ok && (bus.raddr1 == bus.waddr)) begin
      rd1 = bus.wdata;
    end
`endif
  end

  always_comb begin
    rd2 = regs[bus.raddr2];
    if (ZERO_REG && (bus.raddr2 == '0)) begin
      rd2 = '0;
    end
`ifdef REG_FILE_BYPASS_EN
    else if (fwd_ok && (bus.raddr2 == bus.waddr)) begin
      rd2 = bus.wdata;
    end
`endif
  end

`ifndef REG_FILE_BYPASS_EN
  // Forwarding qualifier only feeds the bypass mux; keep it observable-free otherwise.
  logic unused_fwd;
  assign unused_fwd = fwd_ok;
`endif

  assign bus.rdata1 = rd1;
  assign bus.rdata2 = rd2;
endmodule

// File: tb/tb_reg_file_param.sv
// Bench for reg_file_param: default, ZERO_REG=0 and an 8-bit/8-deep instance.
// Expected reads come from plain arrays updated by the write rules.
module tb_reg_file_param;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  reg_file_param_if #(.WIDTH(32), .ADDR_W(5)) rf_a ();
  reg_file_param_if #(.WIDTH(32), .ADDR_W(5)) rf_z ();
  reg_file_param_if #(.WIDTH(8),  .ADDR_W(3)) rf_s ();

  reg_file_param #(.WIDTH(32), .ADDR_W(5), .ZERO_REG(1'b1)) u_a (.clk(clk), .reset(reset), .bus(rf_a));
  reg_file_param #(.WIDTH(32), .ADDR_W(5), .ZERO_REG(1'b0)) u_z (.clk(clk), .reset(reset), .bus(rf_z));
  reg_file_param #(.WIDTH(8),  .ADDR_W(3), .ZERO_REG(1'b1)) u_s (.clk(clk), .reset(reset), .bus(rf_s));

  logic [31:0] ma [32];
  logic [31:0] mz [32];

  typedef struct {
    bit          we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [31:0] e1;
    logic [31:0] e2;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Read value the spec promises for one port while reset is released.
  function automatic logic [31:0] expect_rd(input logic [31:0] stored, input bit zero_reg,
                                            input int ra, input bit we, input int wa,
                                            input logic [31:0] wd);
    if (zero_reg && ra == 0) return 32'h0;
`ifdef REG_FILE_BYPASS_EN
    if (we && ra == wa) return wd;
`endif
    return stored;
  endfunction

  task automatic clear_models();
    for (int i = 0; i < 32; i++) begin
      ma[i] = 32'h0;
      mz[i] = 32'h0;
    end
  endtask

  task automatic idle_all();
    rf_a.we = 1'b0; rf_a.waddr = '0; rf_a.wdata = '0; rf_a.raddr1 = '0; rf_a.raddr2 = '0;
    rf_z.we = 1'b0; rf_z.waddr = '0; rf_z.wdata = '0; rf_z.raddr1 = '0; rf_z.raddr2 = '0;
    rf_s.we = 1'b0; rf_s.waddr = '0; rf_s.wdata = '0; rf_s.raddr1 = '0; rf_s.raddr2 = '0;
  endtask

  task automatic write_a(input logic [4:0] wa, input logic [31:0] wd);
    @(negedge clk);
    rf_a.we = 1'b1; rf_a.waddr = wa; rf_a.wdata = wd;
    @(posedge clk);
    if (wa != 5'd0) ma[wa] = wd;
    #1;
    rf_a.we = 1'b0;
  endtask

  initial begin
    logic        we;
    logic [4:0]  wa, r1, r2;
    logic [31:0] wd;
    logic [7:0]  es;

    idle_all();
    clear_models();

    vecs[0] = '{1'b1, 5'd5,  32'hAFAFAFAF, 5'd5,  5'd6,  32'hAFAFAFAF, 32'h0};
    vecs[1] = '{1'b1, 5'd0,  32'hDEADBEEF, 5'd0,  5'd5,  32'h0,        32'hAFAFAFAF};
    vecs[2] = '{1'b0, 5'd5,  32'h12345678, 5'd5,  5'd0,  32'hAFAFAFAF, 32'h0};
    vecs[3] = '{1'b1, 5'd31, 32'hCAFEF00D, 5'd31, 5'd5,  32'hCAFEF00D, 32'hAFAFAFAF};
    vecs[4] = '{1'b1, 5'd5,  32'h00000001, 5'd5,  5'd31, 32'h00000001, 32'hCAFEF00D};
    vecs[5] = '{1'b1, 5'd6,  32'hFFFFFFFF, 5'd6,  5'd6,  32'hFFFFFFFF, 32'hFFFFFFFF};

    // Reset held across clock edges, writes attempted meanwhile.
    #2 reset = 1'b0;
    rf_a.we = 1'b1; rf_a.waddr = 5'd7; rf_a.wdata = 32'h5A5A5A5A;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rf_a.we = 1'b0;
    rf_a.raddr1 = 5'd7; rf_a.raddr2 = 5'd31;
    #1;
    check("reset_rd1", rf_a.rdata1, 32'h0);
    check("reset_rd2", rf_a.rdata2, 32'h0);
    reset = 1'b1;
    @(posedge clk); #1;
    check("post_reset_rd1", rf_a.rdata1, 32'h0);
    check("post_reset_rd2", rf_a.rdata2, 32'h0);

    // Table-driven write then read.
    for (int v = 0; v < 6; v++) begin
      @(negedge clk);
      rf_a.we = vecs[v].we; rf_a.waddr = vecs[v].waddr; rf_a.wdata = vecs[v].wdata;
      @(posedge clk);
      if (vecs[v].we && vecs[v].waddr != 5'd0) ma[vecs[v].waddr] = vecs[v].wdata;
      #1;
      rf_a.we = 1'b0; rf_a.wdata = 32'h0;
      rf_a.raddr1 = vecs[v].ra1; rf_a.raddr2 = vecs[v].ra2;
      #1;
      check($sformatf("vec%0d_rd1", v), rf_a.rdata1, vecs[v].e1);
      check($sformatf("vec%0d_rd2", v), rf_a.rdata2, vecs[v].e2);
    end

    // Register 0 is ordinary storage when ZERO_REG=0.
    @(negedge clk);
    rf_z.we = 1'b1; rf_z.waddr = 5'd0; rf_z.wdata = 32'hDEADBEEF;
    @(posedge clk);
    mz[0] = 32'hDEADBEEF;
    #1;
    rf_z.we = 1'b0; rf_z.raddr1 = 5'd0;
    #1;
    check("zreg0_rd1", rf_z.rdata1, 32'hDEADBEEF);

    // Same-cycle collision on register 9.
    write_a(5'd9, 32'h11111111);
    @(negedge clk);
    rf_a.we = 1'b1; rf_a.waddr = 5'd9; rf_a.wdata = 32'h22222222;
    rf_a.raddr1 = 5'd9; rf_a.raddr2 = 5'd0;
    #1;
`ifdef REG_FILE_BYPASS_EN
    check("collide_pre", rf_a.rdata1, 32'h22222222);
`else
    check("collide_pre", rf_a.rdata1, 32'h11111111);
`endif
    check("collide_zero_port", rf_a.rdata2, 32'h0);
    @(posedge clk);
    ma[9] = 32'h22222222;
    #1;
    check("collide_post", rf_a.rdata1, 32'h22222222);
    rf_a.we = 1'b0;

    // Write to register 0 must never be forwarded.
    @(negedge clk);
    rf_a.we = 1'b1; rf_a.waddr = 5'd0; rf_a.wdata = 32'h33333333; rf_a.raddr1 = 5'd0;
    #1;
    check("zero_no_fwd", rf_a.rdata1, 32'h0);
    @(posedge clk); #1;
    rf_a.we = 1'b0;

    // Random traffic against the array model, biased toward read/write collisions.
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      we = 1'($urandom_range(0, 1));
      wa = 5'($urandom_range(0, 31));
      wd = $urandom;
      r1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      r2 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      rf_a.we = we; rf_a.waddr = wa; rf_a.wdata = wd; rf_a.raddr1 = r1; rf_a.raddr2 = r2;
      rf_z.we = we; rf_z.waddr = wa; rf_z.wdata = wd; rf_z.raddr1 = r1; rf_z.raddr2 = r2;
      #1;
      check("rand_a_rd1", rf_a.rdata1, expect_rd(ma[r1], 1'b1, int'(r1), we, int'(wa), wd));
      check("rand_a_rd2", rf_a.rdata2, expect_rd(ma[r2], 1'b1, int'(r2), we, int'(wa), wd));
      check("rand_z_rd1", rf_z.rdata1, expect_rd(mz[r1], 1'b0, int'(r1), we, int'(wa), wd));
      check("rand_z_rd2", rf_z.rdata2, expect_rd(mz[r2], 1'b0, int'(r2), we, int'(wa), wd));
      @(posedge clk);
      if (we && wa != 5'd0) ma[wa] = wd;
      if (we) mz[wa] = wd;
    end
    @(negedge clk);
    idle_all();

    // Async reset in the middle of a loaded file.
    for (int i = 1; i < 32; i++) write_a(5'(i), 32'(i));
    @(negedge clk);
    rf_a.raddr1 = 5'd31; rf_a.raddr2 = 5'd1;
    #1;
    check("loaded_rd1", rf_a.rdata1, 32'd31);
    check("loaded_rd2", rf_a.rdata2, 32'd1);
    #1 reset = 1'b0;
    #1;
    check("async_rst_rd1", rf_a.rdata1, 32'h0);
    check("async_rst_rd2", rf_a.rdata2, 32'h0);
    clear_models();
    rf_a.we = 1'b1; rf_a.waddr = 5'd3; rf_a.wdata = 32'hFFFFFFFF;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    rf_a.we = 1'b0; rf_a.raddr1 = 5'd3;
    #1;
    check("write_in_reset_lost", rf_a.rdata1, 32'h0);

    // Narrow instance: WIDTH=8, ADDR_W=3.
    @(negedge clk);
    rf_s.we = 1'b1; rf_s.waddr = 3'd7; rf_s.wdata = 8'hFF;
    @(negedge clk);
    rf_s.waddr = 3'd1; rf_s.wdata = 8'h01;
    @(negedge clk);
    rf_s.we = 1'b0;
    for (int a = 0; a < 8; a++) begin
      rf_s.raddr1 = 3'(a); rf_s.raddr2 = 3'(7 - a);
      #1;
      es = (a == 7) ? 8'hFF : (a == 1) ? 8'h01 : 8'h00;
      check($sformatf("narrow_rd1_a%0d", a), {24'h0, rf_s.rdata1}, {24'h0, es});
      es = ((7 - a) == 7) ? 8'hFF : ((7 - a) == 1) ? 8'h01 : 8'h00;
      check($sformatf("narrow_rd2_a%0d", 7 - a), {24'h0, rf_s.rdata2}, {24'h0, es});
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
